// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: MSHR sizing, index/vector types and a one-hot decode helper.
package rvh_l1d_pkg;

    localparam int N_MSHR    = 8;
    localparam int MSHR_ID_W = $clog2(N_MSHR);

    typedef logic [MSHR_ID_W-1:0] mshr_id_t;
    typedef logic [N_MSHR-1:0]    mshr_vec_t;

    // Widest one-hot vector the decode helper accepts; callers zero-extend.
    localparam int OH_MAX_W = 64;

    // One-hot to binary. OR-ing the indices of set bits is exact for a one-hot
    // input and yields 0 for an all-zero input, which is what the full case wants.
    function automatic logic [31:0] oh_to_bin(input logic [OH_MAX_W-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_hot_priority_encoder.sv
// Lowest-index-wins priority select: returns a one-hot (or zero) grant vector.
module one_hot_priority_encoder #(
    parameter int SEL_WIDTH = 8
) (
    input  logic [SEL_WIDTH-1:0] req_i,
    output logic [SEL_WIDTH-1:0] gnt_o,
    output logic                 any_o
);

    // seen[k] is high when any request at index 0..k is set.
    logic [SEL_WIDTH-1:0] seen;

    assign seen[0]  = req_i[0];
    assign gnt_o[0] = req_i[0];

    genvar gi;
    generate
        for (gi = 1; gi < SEL_WIDTH; gi++) begin : g_sel
            assign gnt_o[gi] = req_i[gi] & ~seen[gi-1];
            assign seen[gi]  = seen[gi-1] | req_i[gi];
        end
    endgenerate

    assign any_o = seen[SEL_WIDTH-1];

endmodule

// File: rtl/rvh_l1d_mshr_alloc.sv
// MSHR allocation / free-list tracker: grants the lowest free entry, retires
// entries on dealloc, and exports occupancy status for back-pressure.
module rvh_l1d_mshr_alloc #(
    parameter int N_MSHR       = 8,
    parameter int ID_W         = $clog2(N_MSHR),
    parameter int AFULL_THRESH = N_MSHR - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_vld_i,
    output logic              alloc_rdy_o,
    output logic [ID_W-1:0]   alloc_id_o,
    output logic [N_MSHR-1:0] alloc_oh_o,
    input  logic              dealloc_vld_i,
    input  logic [ID_W-1:0]   dealloc_id_i,
    input  logic              flush_i,
    output logic [N_MSHR-1:0] entry_vld_o,
    output logic [ID_W:0]     free_cnt_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              err_dealloc_o
);

    import rvh_l1d_pkg::*;

    localparam int CNT_W = ID_W + 1;

    logic [N_MSHR-1:0] entry_vld_q, entry_vld_d;
    logic [CNT_W-1:0]  free_cnt_q,  free_cnt_d;
    logic              err_q,       err_d;

    logic [N_MSHR-1:0] alloc_oh;
    logic              alloc_any;
    logic              alloc_fire;
    logic              dealloc_hit;
    logic              dealloc_bad;

    // Free-entry select is purely from registered state: zero-cycle grant and
    // no bypass of an entry being freed in the same cycle.
    one_hot_priority_encoder #(
        .SEL_WIDTH (N_MSHR)
    ) u_free_sel (
        .req_i (~entry_vld_q),
        .gnt_o (alloc_oh),
        .any_o (alloc_any)
    );

    assign alloc_oh_o  = alloc_oh;
    assign alloc_rdy_o = alloc_any;
    assign alloc_id_o  = ID_W'(oh_to_bin(OH_MAX_W'(alloc_oh)));

    assign alloc_fire  = alloc_vld_i & alloc_any;
    assign dealloc_hit = dealloc_vld_i &  entry_vld_q[dealloc_id_i];
    assign dealloc_bad = dealloc_vld_i & ~entry_vld_q[dealloc_id_i];

    // Next-state: flush wins over alloc/dealloc; illegal deallocs never touch the count.
    always_comb begin
        entry_vld_d = entry_vld_q;
        free_cnt_d  = free_cnt_q;
        err_d       = err_q | dealloc_bad;
        if (flush_i) begin
            entry_vld_d = '0;
            free_cnt_d  = CNT_W'(N_MSHR);
        end else begin
            if (alloc_fire) begin
                entry_vld_d = entry_vld_d | alloc_oh;
            end
            if (dealloc_hit) begin
                entry_vld_d[dealloc_id_i] = 1'b0;
            end
            free_cnt_d = free_cnt_q - CNT_W'(alloc_fire) + CNT_W'(dealloc_hit);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_vld_q <= '0;
            free_cnt_q  <= CNT_W'(N_MSHR);
            err_q       <= 1'b0;
        end else begin
            entry_vld_q <= entry_vld_d;
            free_cnt_q  <= free_cnt_d;
            err_q       <= err_d;
        end
    end

    assign entry_vld_o   = entry_vld_q;
    assign free_cnt_o    = free_cnt_q;
    assign full_o        = (free_cnt_q == '0);
    assign empty_o       = (free_cnt_q == CNT_W'(N_MSHR));
    assign almost_full_o = (free_cnt_q <= CNT_W'(AFULL_THRESH));
    assign err_dealloc_o = err_q;

    // The counter must always agree with the valid vector.
    a_cnt_matches_vec: assert property (@(posedge clk) disable iff (!rst_n)
        free_cnt_q == CNT_W'(N_MSHR) - CNT_W'($countones(entry_vld_q)));

    // The grant is one-hot, or zero when no entry is free.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(alloc_oh));

endmodule

// File: doc/rvh_l1d_mshr_alloc.md
Name: rvh_l1d_mshr_alloc

Overview:
- Allocation and free-list tracker for the L1D miss status holding registers (MSHRs).
- Keeps a per-entry valid vector and selects the lowest-index free entry through the one-hot priority encoder.
- Grants that entry to the miss-request path with a valid/ready handshake.
- Frees entries when the refill/writeback path retires them, and exports occupancy status for back-pressure.

Parameters:
- N_MSHR, 8: number of MSHR entries; power of two, at least 2.
- ID_W, $clog2(N_MSHR): width of an entry index.
- AFULL_THRESH, N_MSHR-2: almost_full_o asserts when the free count is at or below this value.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- alloc_vld_i  input  1  miss path requests an MSHR entry
- alloc_rdy_o  output  1  a free entry exists; a handshake completes when vld&rdy
- alloc_id_o  output  ID_W  binary index of the granted entry; valid when alloc_rdy_o=1
- alloc_oh_o  output  N_MSHR  one-hot form of alloc_id_o; all zero when full
- dealloc_vld_i  input  1  retire an entry this cycle
- dealloc_id_i  input  ID_W  index of the entry to retire
- flush_i  input  1  synchronous clear of all entries (fence/kill)
- entry_vld_o  output  N_MSHR  registered valid vector
- free_cnt_o  output  ID_W+1  registered number of free entries
- full_o  output  1  free_cnt_o==0
- empty_o  output  1  free_cnt_o==N_MSHR
- almost_full_o  output  1  free_cnt_o<=AFULL_THRESH
- err_dealloc_o  output  1  sticky flag: a dealloc targeted an entry that was not valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - entry_vld=0 and free_cnt=N_MSHR.
  - err_dealloc_o=0.
  - Derived outputs at reset: alloc_rdy_o=1, alloc_id_o=0, alloc_oh_o=1, empty_o=1, full_o=0, almost_full_o=0.
- Grant path (combinational from registered state):
  - alloc_oh_o = priority_encode(~entry_vld), so the lowest free index wins.
  - alloc_id_o is the binary encoding of alloc_oh_o.
  - alloc_rdy_o = |(~entry_vld).
  - Zero-cycle grant latency; alloc_rdy_o does not depend on alloc_vld_i.
- Allocate:
  - On vld&rdy at a rising edge, entry_vld[alloc_id_o] is set in the next cycle.
  - At most one allocation per cycle.
  - Requester rule: while alloc_vld_i is held without a handshake, alloc_id_o may change only if a dealloc frees a lower index.
- Deallocate:
  - dealloc_vld_i with entry_vld[dealloc_id_i]=1 clears that bit in the next cycle.
  - If the bit is already 0: no state change, and err_dealloc_o is set and held until reset.
- Simultaneous alloc and dealloc:
  - Both take effect and free_cnt is unchanged.
  - A freed entry is not bypassed: it becomes allocatable only from the next cycle.
  - Different indices are guaranteed, because the granted entry is free and the deallocated entry is valid.
- Full:
  - alloc_rdy_o=0 and alloc_oh_o=0; alloc_id_o is held at 0 (don't-care for consumers).
  - alloc_vld_i is ignored.
- flush_i:
  - Highest priority: next state is entry_vld=0 and free_cnt=N_MSHR, overriding any same-cycle alloc or dealloc.
  - An alloc handshake in the flush cycle is lost, so the requester must reissue.
  - err_dealloc_o is not cleared by flush.
- free_cnt:
  - Updated as free_cnt - alloc_fire + dealloc_fire, computed at ID_W+1 bits.
  - Invariant: free_cnt == N_MSHR - popcount(entry_vld). An assertion checks this every cycle.
  - Never underflows or overflows, because illegal deallocs do not count.
- Reset mid-operation: all state returns to reset values immediately; in-flight handshakes are discarded.

Decomposition:
- Shared package (rvh_l1d_pkg):
  - N_MSHR and the derived MSHR_ID_W constant.
  - mshr_id_t typedef (logic [MSHR_ID_W-1:0]).
  - mshr_vec_t typedef (logic [N_MSHR-1:0]).
- Sub-modules:
  - Instantiate one_hot_priority_encoder (SEL_WIDTH=N_MSHR) for the free-entry select.
  - Write a small one-hot-to-binary function in the package.
  - No other sub-module is needed.

Test Plan:
- Reset, then alloc_vld_i=1 for 8 cycles → ids 0,1,…,7 in order; after the 8th, full_o=1, alloc_rdy_o=0, alloc_oh_o=0, free_cnt_o=0.
- From full, dealloc id 5 → next cycle alloc_rdy_o=1, alloc_id_o=5, free_cnt_o=1, almost_full_o=1; then alloc → full again.
- Entries 0-3 valid, same cycle alloc (grant id 4) and dealloc id 1 → next cycle entry_vld=8'b0001_1101, free_cnt unchanged at 4, alloc_id_o=1.
- Dealloc id 6 while entry 6 is invalid → entry_vld and free_cnt unchanged, err_dealloc_o=1 and stays 1 across a later flush.
- 6 entries valid, flush_i=1 together with alloc_vld_i=1 and dealloc_vld_i=1 → next cycle entry_vld=0, free_cnt_o=8, empty_o=1.
- Random alloc/dealloc for 10k cycles with rst_n asserted asynchronously mid-run → outputs reach reset values without a clock edge; the free_cnt/popcount invariant and one-hot-or-zero alloc_oh_o assertions never fire.
